pattern_scheduler: RTL and testbench

PATTERN_SCHEDULER -- requirements
Module: pattern_scheduler

---
 rtl/pattern_scheduler.sv | 136 +++++++++++++
 tb/tb_pattern_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_scheduler.sv
// Test-pattern mode scheduler: picks the pattern mode once per video frame,
// either from switches, by timed auto-rotation, or from a held forced request.
module pattern_scheduler #(
  parameter int DWELL_W         = 7,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               iVGA_V_SYNC,
  input  logic [1:0]         iMode_sel,
  input  logic               iAuto_en,
  input  logic [DWELL_W-1:0] iDwell,
  input  logic               iReq,
  input  logic [1:0]         iReq_mode,
  output logic               oAck,
  output logic [1:0]         oMode,
  output logic               oSwap,
  output logic [6:0]         oFrame_count,
  output logic               oFrame_start,
  output logic [1:0]         oState
);

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    AUTO   = 2'b01,
    HOLD   = 2'b10
  } state_t;

  state_t             state_reg, state_next;
  logic [1:0]         mode_reg, mode_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next, dwell_last;
  logic [6:0]         count_reg, count_next;
  logic               vsync_prev_reg;
  logic               frame_start_reg;
  logic               ack_reg;
  logic               boundary;
  logic               accept;
  logic               dwell_done;

  assign boundary = SYNC_ACTIVE_LOW ? (vsync_prev_reg & ~iVGA_V_SYNC)
                                    : (~vsync_prev_reg & iVGA_V_SYNC);

  // A dwell of 0 behaves as 1; ">=" keeps the counter from running away
  // if the dwell input is lowered while a count is in progress.
  assign dwell_last = (iDwell == '0) ? '0 : (iDwell - DWELL_W'(1));
  assign dwell_done = (dwell_reg >= dwell_last);

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    dwell_next = dwell_reg;
    accept     = 1'b0;
    if (iReq) begin
      accept     = 1'b1;
      state_next = HOLD;
      mode_next  = iReq_mode;
      dwell_next = '0;
    end else begin
      case (state_reg)
        MANUAL: begin
          dwell_next = '0;
          if (iAuto_en) state_next = AUTO;
          else          mode_next  = iMode_sel;
        end
        AUTO: begin
          if (!iAuto_en) begin
            state_next = MANUAL;
            mode_next  = iMode_sel;
            dwell_next = '0;
          end else if (dwell_done) begin
            mode_next  = mode_reg + 2'd1;
            dwell_next = '0;
          end else begin
            dwell_next = dwell_reg + DWELL_W'(1);
          end
        end
        HOLD: begin
          if (dwell_done) begin
            dwell_next = '0;
            if (iAuto_en) begin
              // Forced mode has used its dwell slot, so rotation resumes at the next mode.
              state_next = AUTO;
              mode_next  = mode_reg + 2'd1;
            end else begin
              state_next = MANUAL;
              mode_next  = iMode_sel;
            end
          end else begin
            dwell_next = dwell_reg + DWELL_W'(1);
          end
        end
        default: begin
          state_next = MANUAL;
          dwell_next = '0;
        end
      endcase
    end
  end

  // Entering mode 0 restarts the bar phase: from mode 1 on X bars, otherwise on Y bars.
  always_comb begin
    count_next = count_reg + 7'd1;
    if (mode_next == 2'b00 && mode_reg != 2'b00)
      count_next = (mode_reg == 2'b01) ? 7'd0 : 7'd64;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg       <= MANUAL;
      mode_reg        <= 2'b00;
      dwell_reg       <= '0;
      count_reg       <= 7'd0;
      vsync_prev_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      ack_reg         <= 1'b0;
    end else begin
      vsync_prev_reg  <= iVGA_V_SYNC;
      frame_start_reg <= boundary;
      ack_reg         <= boundary & accept;
      if (boundary) begin
        state_reg <= state_next;
        mode_reg  <= mode_next;
        dwell_reg <= dwell_next;
        count_reg <= count_next;
      end
    end
  end

  assign oAck         = ack_reg;
  assign oMode        = mode_reg;
  assign oFrame_count = count_reg;
  assign oSwap        = count_reg[6];
  assign oFrame_start = frame_start_reg;
  assign oState       = state_reg;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Bench for pattern_scheduler: directed frames push hand-computed expectations,
// a monitor pops one per oFrame_start and checks outputs stay put in between.
module tb_pattern_scheduler;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       iVGA_V_SYNC = 1'b0;
  logic [1:0] iMode_sel = 2'b00;
  logic       iAuto_en = 1'b0;
  logic [6:0] iDwell = 7'd3;
  logic       iReq = 1'b0;
  logic [1:0] iReq_mode = 2'b00;
  logic       oAck;
  logic [1:0] oMode;
  logic       oSwap;
  logic [6:0] oFrame_count;
  logic       oFrame_start;
  logic [1:0] oState;

  pattern_scheduler dut (
    .Clock(Clock), .Resetn(Resetn), .iVGA_V_SYNC(iVGA_V_SYNC),
    .iMode_sel(iMode_sel), .iAuto_en(iAuto_en), .iDwell(iDwell),
    .iReq(iReq), .iReq_mode(iReq_mode), .oAck(oAck), .oMode(oMode),
    .oSwap(oSwap), .oFrame_count(oFrame_count), .oFrame_start(oFrame_start),
    .oState(oState)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] state;
    logic [6:0] cnt;
    logic       ack;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [1:0] last_mode = 2'b00;
  logic [1:0] last_state = 2'b00;
  logic [6:0] last_cnt = 7'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: consume one expectation per frame start, otherwise outputs must hold.
  always @(negedge Clock) begin
    if (!Resetn) begin
      last_mode  = 2'b00;
      last_state = 2'b00;
      last_cnt   = 7'd0;
    end else if (oFrame_start) begin
      if (q.size() == 0) begin
        check("unexpected_frame_start", 1, 0);
        last_mode  = oMode;
        last_state = oState;
        last_cnt   = oFrame_count;
      end else begin
        exp_t e;
        e = q.pop_front();
        check("mode", int'(oMode), int'(e.mode));
        check("state", int'(oState), int'(e.state));
        check("frame_count", int'(oFrame_count), int'(e.cnt));
        check("swap", int'(oSwap), int'(e.cnt[6]));
        check("ack", int'(oAck), int'(e.ack));
        $display("frame: mode=%0d state=%0d count=%0d swap=%0d ack=%0d", oMode, oState, oFrame_count, oSwap, oAck);
        last_mode  = e.mode;
        last_state = e.state;
        last_cnt   = e.cnt;
      end
    end else begin
      check("hold_between_frames", int'({oAck, oMode, oState, oFrame_count}),
            int'({1'b0, last_mode, last_state, last_cnt}));
    end
  end

  task automatic frame(input logic [1:0] m, input logic [1:0] s, input int c, input logic a);
    exp_t e;
    e.mode = m; e.state = s; e.cnt = 7'(c); e.ack = a;
    q.push_back(e);
    @(negedge Clock) iVGA_V_SYNC = 1'b1;
    repeat (3) @(negedge Clock);
    iVGA_V_SYNC = 1'b0;
    repeat (3) @(negedge Clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mode"}, int'(oMode), 0);
    check({tag, "_state"}, int'(oState), 0);
    check({tag, "_count"}, int'(oFrame_count), 0);
    check({tag, "_swap"}, int'(oSwap), 0);
    check({tag, "_ack"}, int'(oAck), 0);
    check({tag, "_frame_start"}, int'(oFrame_start), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clock);
    check_reset_outputs("reset");
    #2 Resetn = 1'b1;

    // Manual selection, mid-frame switch changes only land at the boundary
    frame(2'd0, 2'd0, 1, 1'b0);
    iMode_sel = 2'd2; frame(2'd2, 2'd0, 2, 1'b0);
    iMode_sel = 2'd1; frame(2'd1, 2'd0, 3, 1'b0);

    // Auto rotation, dwell 3, entry to mode 0 from mode 3 loads 64
    iAuto_en = 1'b1;
    frame(2'd1, 2'd1, 4, 1'b0); frame(2'd1, 2'd1, 5, 1'b0); frame(2'd1, 2'd1, 6, 1'b0);
    frame(2'd2, 2'd1, 7, 1'b0); frame(2'd2, 2'd1, 8, 1'b0); frame(2'd2, 2'd1, 9, 1'b0);
    frame(2'd3, 2'd1, 10, 1'b0); frame(2'd3, 2'd1, 11, 1'b0); frame(2'd3, 2'd1, 12, 1'b0);
    frame(2'd0, 2'd1, 64, 1'b0); frame(2'd0, 2'd1, 65, 1'b0); frame(2'd0, 2'd1, 66, 1'b0);
    frame(2'd1, 2'd1, 67, 1'b0);

    // Forced request in AUTO with dwell 2
    iDwell = 7'd2; iReq = 1'b1; iReq_mode = 2'd3; iMode_sel = 2'd0;
    frame(2'd3, 2'd2, 68, 1'b1);
    iReq = 1'b0;
    frame(2'd3, 2'd2, 69, 1'b0);
    frame(2'd0, 2'd1, 64, 1'b0);
    frame(2'd0, 2'd1, 65, 1'b0);
    frame(2'd1, 2'd1, 66, 1'b0);

    // Dwell 0 acts as 1
    iDwell = 7'd0;
    frame(2'd2, 2'd1, 67, 1'b0);
    frame(2'd3, 2'd1, 68, 1'b0);
    frame(2'd0, 2'd1, 64, 1'b0);

    // Counter wrap 127 -> 0 without a mode-0 entry
    iAuto_en = 1'b0; iMode_sel = 2'd1;
    frame(2'd1, 2'd0, 65, 1'b0);
    for (int c = 66; c <= 127; c++) frame(2'd1, 2'd0, c, 1'b0);
    frame(2'd1, 2'd0, 0, 1'b0);

    // Request and auto-disable on the same boundary
    iAuto_en = 1'b1;
    frame(2'd1, 2'd1, 1, 1'b0);
    iDwell = 7'd2; iReq = 1'b1; iReq_mode = 2'd2; iAuto_en = 1'b0; iMode_sel = 2'd3;
    frame(2'd2, 2'd2, 2, 1'b1);
    iReq = 1'b0;
    frame(2'd2, 2'd2, 3, 1'b0);
    frame(2'd3, 2'd0, 4, 1'b0);

    // Request dropped before the boundary gets no ack
    iReq = 1'b1;
    repeat (2) @(negedge Clock);
    iReq = 1'b0;
    frame(2'd3, 2'd0, 5, 1'b0);

    // Held request re-arms on the following boundary
    iDwell = 7'd3; iReq = 1'b1; iReq_mode = 2'd1;
    frame(2'd1, 2'd2, 6, 1'b1);
    frame(2'd1, 2'd2, 7, 1'b1);

    // Asynchronous reset during HOLD with the request still held
    @(negedge Clock) iVGA_V_SYNC = 1'b1;
    repeat (2) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge Clock);
    #2 Resetn = 1'b1;
    frame(2'd1, 2'd2, 1, 1'b1);
    iReq = 1'b0; iAuto_en = 1'b0; iMode_sel = 2'd3;
    frame(2'd1, 2'd2, 2, 1'b0);
    frame(2'd1, 2'd2, 3, 1'b0);
    frame(2'd3, 2'd0, 4, 1'b0);

    repeat (4) @(negedge Clock);
    check("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
